// File: rtl/regfile_seq_pkg.sv
// Shared constants and encodings for the register-file operation sequencer.
package regfile_seq_pkg;

  localparam int unsigned DEF_DW = 16;
  localparam int unsigned DEF_AW = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MOV = 3'b101,
    OP_LDI = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_EXEC  = 2'b10,
    S_WRITE = 2'b11
  } state_e;

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer: result plus carry/borrow for arithmetic ops.
module seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
) (
  input  logic [2:0]    i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [DW-1:0] i_imm,
  output logic [DW-1:0] o_res,
  output logic          o_carry
);

  logic [DW:0] w_sum;
  logic [DW:0] w_diff;

  // Extended-width add/sub so the top bit is carry-out or borrow (a < b unsigned).
  always_comb begin
    w_sum   = {1'b0, i_a} + {1'b0, i_b};
    w_diff  = {1'b0, i_a} - {1'b0, i_b};
    o_res   = '0;
    o_carry = 1'b0;
    unique case (op_e'(i_op))
      OP_ADD: begin
        o_res   = w_sum[DW-1:0];
        o_carry = w_sum[DW];
      end
      OP_SUB, OP_CMP: begin
        o_res   = w_diff[DW-1:0];
        o_carry = w_diff[DW];
      end
      OP_AND: o_res = i_a & i_b;
      OP_OR:  o_res = i_a | i_b;
      OP_XOR: o_res = i_a ^ i_b;
      OP_MOV: o_res = i_a;
      OP_LDI: o_res = i_imm;
      default: begin
        o_res   = '0;
        o_carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_op_seq.sv
// Initiator-side sequencer: one command per handshake, read -> execute -> write back.
module regfile_op_seq
  import regfile_seq_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs,
  input  logic [AW-1:0] cmd_rt,
  input  logic [DW-1:0] cmd_imm,
  output logic [AW-1:0] RA,
  output logic [AW-1:0] RB,
  input  logic [DW-1:0] busA,
  input  logic [DW-1:0] busB,
  output logic [AW-1:0] RW,
  output logic [DW-1:0] busW,
  output logic          WE,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          zf,
  output logic          cf
);

  state_e        r_state;
  state_e        w_state_next;
  logic          w_fire;

  logic [2:0]    r_op;
  logic [AW-1:0] r_rd;
  logic [DW-1:0] r_imm;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [AW-1:0] r_ra;
  logic [AW-1:0] r_rb;
  logic [AW-1:0] r_rw;
  logic [DW-1:0] r_busw;
  logic          r_we;
  logic          r_done;
  logic [DW-1:0] r_result;
  logic          r_zf;
  logic          r_cf;

  logic [DW-1:0] w_res;
  logic          w_carry;

  assign cmd_ready = (r_state == S_IDLE);
  assign w_fire    = cmd_valid & cmd_ready;

  assign RA     = r_ra;
  assign RB     = r_rb;
  assign RW     = r_rw;
  assign busW   = r_busw;
  assign WE     = r_we;
  assign done   = r_done;
  assign result = r_result;
  assign zf     = r_zf;
  assign cf     = r_cf;

  seq_alu #(
    .DW (DW)
  ) u_alu (
    .i_op    (r_op),
    .i_a     (r_a),
    .i_b     (r_b),
    .i_imm   (r_imm),
    .o_res   (w_res),
    .o_carry (w_carry)
  );

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: fixed four-step walk once a command is accepted.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_fire) w_state_next = S_READ;
      S_READ:  w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_WRITE;
      S_WRITE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: latch command, capture operands, register result and write-back strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_rd     <= '0;
      r_imm    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_ra     <= '0;
      r_rb     <= '0;
      r_rw     <= '0;
      r_busw   <= '0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_zf     <= 1'b0;
      r_cf     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_op  <= cmd_op;
            r_rd  <= cmd_rd;
            r_imm <= cmd_imm;
            r_ra  <= cmd_rs;
            r_rb  <= cmd_rt;
          end
        end
        S_READ: begin
          r_a <= busA;
          r_b <= busB;
        end
        S_EXEC: begin
          r_rw     <= r_rd;
          r_busw   <= w_res;
          // CMP only updates flags/result; the register file is left alone.
          r_we     <= (r_op != OP_CMP);
          r_done   <= 1'b1;
          r_result <= w_res;
          r_zf     <= (w_res == '0);
          r_cf     <= w_carry;
        end
        S_WRITE: begin
          r_we   <= 1'b0;
          r_done <= 1'b0;
        end
        default: begin
          r_we   <= 1'b0;
          r_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_op_seq.sv
// Self-checking bench: directed cases plus random commands against an array-based model.
module tb_regfile_op_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [2:0]  cmd_rd = '0;
  logic [2:0]  cmd_rs = '0;
  logic [2:0]  cmd_rt = '0;
  logic [15:0] cmd_imm = '0;
  logic [2:0]  RA, RB, RW;
  logic [15:0] busA, busB, busW;
  logic        WE, done;
  logic [15:0] result;
  logic        zf, cf;

  int n_checks = 0;
  int n_errors = 0;

  // Register file the sequencer drives, plus the bench's own expected contents.
  logic [15:0] rf     [8] = '{default: 16'h0000};
  logic [15:0] ref_rf [8] = '{default: 16'h0000};
  int          wr7_cnt = 0;

  assign busA = rf[RA];
  assign busB = rf[RB];

  always @(posedge clk) begin
    if (WE) rf[RW] <= busW;
    if (WE && RW == 3'd7) wr7_cnt <= wr7_cnt + 1;
  end

  always #5 clk = ~clk;

  regfile_op_seq #(
    .DW (16),
    .AW (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs    (cmd_rs),
    .cmd_rt    (cmd_rt),
    .cmd_imm   (cmd_imm),
    .RA        (RA),
    .RB        (RB),
    .busA      (busA),
    .busB      (busB),
    .RW        (RW),
    .busW      (busW),
    .WE        (WE),
    .done      (done),
    .result    (result),
    .zf        (zf),
    .cf        (cf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference semantics written from the operation table with plain integer arithmetic.
  function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] imm, output logic [15:0] res,
                                output logic cy, output logic wr);
    int unsigned ua = a;
    int unsigned ub = b;
    int unsigned t;
    wr  = 1'b1;
    cy  = 1'b0;
    res = '0;
    case (op)
      3'd0: begin t = ua + ub; res = 16'(t % 65536); cy = (t >= 65536); end
      3'd1: begin t = ua + 65536 - ub; res = 16'(t % 65536); cy = (ua < ub); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = a;
      3'd6: res = imm;
      default: begin t = ua + 65536 - ub; res = 16'(t % 65536); cy = (ua < ub); wr = 1'b0; end
    endcase
  endfunction

  task automatic wait_ready();
    int waits = 0;
    while (!cmd_ready && waits < 20) begin
      @(posedge clk); #1;
      waits++;
    end
    check_eq("ready_wait", cmd_ready, 1);
  endtask

  // Issue one command and follow it edge by edge; called with time #1 after an edge.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [15:0] imm, input bit hold_valid);
    logic [15:0] res;
    logic        cy, wr;
    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm;
    cmd_valid = 1'b1;
    wait_ready();
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    model(op, ref_rf[rs], ref_rf[rt], imm, res, cy, wr);
    @(posedge clk); #1;  // READ
    if (!hold_valid) cmd_valid = 1'b0;
    check_eq("read_ready", cmd_ready, 0);
    check_eq("read_ra", RA, rs);
    check_eq("read_rb", RB, rt);
    check_eq("read_done", done, 0);
    @(posedge clk); #1;  // EXEC
    check_eq("exec_ready", cmd_ready, 0);
    check_eq("exec_we", WE, 0);
    check_eq("exec_done", done, 0);
    @(posedge clk); #1;  // WRITE
    check_eq("wr_ready", cmd_ready, 0);
    check_eq("wr_done", done, 1);
    check_eq("wr_we", WE, wr);
    check_eq("wr_result", result, res);
    check_eq("wr_zf", zf, (res == 16'h0));
    check_eq("wr_cf", cf, cy);
    if (wr) begin
      check_eq("wr_rw", RW, rd);
      check_eq("wr_busw", busW, res);
    end
    @(posedge clk); #1;  // back in IDLE, write committed
    check_eq("idle_done", done, 0);
    check_eq("idle_we", WE, 0);
    check_eq("idle_ready", cmd_ready, 1);
    check_eq("idle_result", result, res);
    if (wr) ref_rf[rd] = res;
    check_eq("rf_rd", rf[rd], ref_rf[rd]);
  endtask

  // Start a MOV into r7 and pull reset after the given number of post-handshake edges.
  task automatic abort_mov(input int edges);
    int cnt0;
    cnt0 = wr7_cnt;
    cmd_op = 3'd5; cmd_rd = 3'd7; cmd_rs = 3'd1; cmd_rt = 3'd0; cmd_imm = 16'h0;
    cmd_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 1; i < edges; i++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check_eq("abort_we", WE, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_ready", cmd_ready, 1);
    check_eq("abort_result", result, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_nowrite", wr7_cnt, cnt0);
    check_eq("abort_r7", rf[7], ref_rf[7]);
    check_eq("abort_ready_after", cmd_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0]  r_op, r_rd, r_rs, r_rt;
    logic [15:0] r_imm;
    bit          r_hold;

    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check_eq("rst_we", WE, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_zf", zf, 0);
    check_eq("rst_cf", cf, 0);
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_ra", RA, 0);
    check_eq("rst_rw", RW, 0);
    check_eq("rst_busw", busW, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Loads, carry out of ADD, borrow on SUB.
    run_cmd(3'd6, 3'd1, 3'd0, 3'd0, 16'h00FF, 1'b0);
    run_cmd(3'd6, 3'd2, 3'd0, 3'd0, 16'hFF00, 1'b0);
    run_cmd(3'd6, 3'd3, 3'd0, 3'd0, 16'h0100, 1'b0);
    run_cmd(3'd0, 3'd4, 3'd2, 3'd3, 16'h0000, 1'b0);
    check_eq("add_r4", rf[4], 16'h0000);
    run_cmd(3'd1, 3'd5, 3'd3, 3'd2, 16'h0000, 1'b0);
    check_eq("sub_r5", rf[5], 16'h0200);

    // CMP sets flags without writing.
    run_cmd(3'd6, 3'd6, 3'd0, 3'd0, 16'h1234, 1'b0);
    run_cmd(3'd7, 3'd6, 3'd6, 3'd6, 16'hFFFF, 1'b0);
    check_eq("cmp_r6", rf[6], 16'h1234);

    // Self-update with valid held high across back-to-back commands.
    run_cmd(3'd6, 3'd0, 3'd0, 3'd0, 16'h0001, 1'b0);
    for (int i = 0; i < 4; i++) run_cmd(3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1);
    cmd_valid = 1'b0;
    check_eq("selfadd_r0", rf[0], 16'h0010);

    // Reset during EXEC and during WRITE, then a normal command.
    abort_mov(2);
    abort_mov(3);
    run_cmd(3'd5, 3'd7, 3'd1, 3'd0, 16'h0000, 1'b0);
    check_eq("mov_r7", rf[7], 16'h00FF);

    // Random commands against the model.
    for (int i = 0; i < 30; i++) begin
      r_op   = 3'($urandom_range(0, 7));
      r_rd   = 3'($urandom_range(0, 7));
      r_rs   = 3'($urandom_range(0, 7));
      r_rt   = 3'($urandom_range(0, 7));
      r_imm  = 16'($urandom);
      r_hold = 1'($urandom_range(0, 1));
      run_cmd(r_op, r_rd, r_rs, r_rt, r_imm, r_hold);
    end
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) check_eq("final_rf", rf[i], ref_rf[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_op_seq.md
Name: regfile_op_seq

Overview:
- Initiator-side sequencer for the 8x16 register file.
- Accepts one register-to-register command per valid/ready handshake.
- Drives RA/RB, captures busA/busB, computes a 16-bit result, then writes it back through RW/busW/WE.
- Sits between a future instruction decoder and reg_file; it is the only master of the reg_file port.

Parameters:
- DW, 16: data width (busA/busB/busW/imm/result).
- AW, 3: register address width (2^AW registers).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; handshake = cmd_valid & cmd_ready at a rising edge.
- cmd_op  in  3  operation, encodings below.
- cmd_rd  in  AW  destination register.
- cmd_rs  in  AW  source A register.
- cmd_rt  in  AW  source B register.
- cmd_imm  in  DW  immediate, used by LDI only.
- RA  out  AW  reg_file read address A (registered).
- RB  out  AW  reg_file read address B (registered).
- busA  in  DW  reg_file read data A (combinational in reg_file).
- busB  in  DW  reg_file read data B.
- RW  out  AW  reg_file write address (registered).
- busW  out  DW  reg_file write data (registered).
- WE  out  1  reg_file write enable; reg_file writes at the rising edge while WE=1.
- done  out  1  one-cycle pulse, coincident with the write cycle.
- result  out  DW  last computed result; held until the next done.
- zf  out  1  zero flag of last result; updated only with done.
- cf  out  1  carry/borrow flag; updated only with done.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; RA=RB=RW=0, busW=0, WE=0, done=0, result=0, zf=cf=0. Resulting cmd_ready=1.
- Reset asserted mid-command aborts it: WE drops immediately and no write occurs. The command is lost.
- Op encoding:
  - 000 ADD: rs+rt
  - 001 SUB: rs-rt
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 MOV: rs
  - 110 LDI: imm
  - 111 CMP: rs-rt, flags only, no write
- FSM IDLE -> READ -> EXEC -> WRITE -> IDLE. Each state lasts exactly 1 cycle after leaving IDLE.
- IDLE: cmd_ready=1, WE=0. On handshake edge E0, latch op/rd/imm, load RA<=rs and RB<=rt, go to READ.
- READ (E0..E1): RA/RB stable. At E1 capture busA->a_q and busB->b_q, go to EXEC.
- EXEC (E1..E2): at E2 register the ALU result, then:
  - RW<=rd_q, busW<=res.
  - WE<=1 unless op=CMP.
  - done<=1; result<=res.
  - zf <= (res==0).
  - cf <= carry-out of bit DW-1 for ADD, borrow (a_q<b_q unsigned) for SUB/CMP, 0 otherwise.
  - Go to WRITE.
- WRITE (E2..E3): WE/done high for exactly this cycle; reg_file commits at E3. At E3, WE<=0, done<=0, go to IDLE.
- Latency: handshake edge to done-high is 3 edges. Throughput is 1 command per 4 cycles.
- Arithmetic is modulo 2^DW (wrap-around, no saturation). CMP sets result/zf/cf but never asserts WE.
- rd==rs or rd==rt is legal; operands are captured before the write.
- Back-to-back commands: the next read happens at least one cycle after E3. This gives no RAW hazard and needs no forwarding.
- cmd_valid while not ready: command fields are ignored. Caller holds them until the handshake.
- RA/RB hold their last values outside READ. RW/busW hold their last values after WRITE; WE=0 makes this harmless.

Decomposition:
- Package regfile_seq_pkg holds:
  - op encodings: OP_ADD..OP_CMP
  - FSM state encoding: S_IDLE, S_READ, S_EXEC, S_WRITE
  - default DW/AW constants
- One combinational sub-module, seq_alu: inputs op, a, b, imm; outputs res, carry. Instantiated once in EXEC datapath.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> WE=0, done=0, result=0, zf=cf=0, cmd_ready=1.
- LDI: op=110 rd=1 imm=16'h00FF -> done at 3rd edge after handshake, WE=1 RW=1 busW=00FF for one cycle. Model reg1=00FF; next command sees cmd_ready=1.
- ADD carry: r2=FF00, r3=0100, op=ADD rd=4 rs=2 rt=3 -> busW=0000, zf=1, cf=1, r4=0000. Then SUB rd=5 rs=3 rt=2 -> 0200, cf=1 (borrow), zf=0.
- CMP no write: r6=1234, CMP rs=6 rt=6 rd=6 -> zf=1, cf=0, done pulse, WE stays 0, r6 unchanged.
- Self-update back-to-back: r0=0001, cmd_valid held continuously with ADD rd=0 rs=0 rt=0 four times -> r0 = 0002, 0004, 0008, 0010. cmd_ready low 3 of every 4 cycles.
- Reset mid-op: assert rst_n=0 during EXEC of a MOV rd=7 -> WE never high, r7 unchanged. After release, cmd_ready=1 and the next command completes normally.
